// File: rtl/dmem_pkg.sv
// dmem_pkg: shared definitions for the data-memory bridge.
//   - SZ_BYTE / SZ_HALF / SZ_WORD: sizeM encodings (2'b11 is treated as word).
//   - dmem_state_e: bridge FSM states. StDrain is only reachable when DMEM_WBUF_EN is defined.
//   - TIMEOUT_W(): number of bits needed to hold a timeout count up to the given value.
package dmem_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic [1:0] {
        StIdle,
        StReq,
        StDone,
        StDrain
    } dmem_state_e;

    // Minimum width (at least 1) able to represent the value t.
    function automatic int unsigned TIMEOUT_W(input int unsigned t);
        int unsigned w;
        w = 1;
        for (int i = 1; i < 32; i++) begin
            if ((t >> i) != 0) begin
                w = i + 1;
            end
        end
        return w;
    endfunction

endpackage

// File: rtl/dmem_align.sv
// dmem_align: combinational access-size decode for the data-memory bridge.
// Ports:
//   i_size     access size (SZ_BYTE / SZ_HALF / SZ_WORD, 2'b11 acts as word)
//   i_addr_lo  byte address bits [1:0]
//   i_wdata    right-aligned store data
//   o_be       little-endian byte enables
//   o_wdata    store data replicated across all byte lanes
//   o_misalign half on an odd address or word on a non-word address
module dmem_align
    import dmem_pkg::*;
(
    input  logic [1:0]  i_size,
    input  logic [1:0]  i_addr_lo,
    input  logic [31:0] i_wdata,
    output logic [3:0]  o_be,
    output logic [31:0] o_wdata,
    output logic        o_misalign
);

    always_comb begin
        o_be       = 4'b1111;
        o_wdata    = i_wdata;
        o_misalign = 1'b0;
        case (i_size)
            SZ_BYTE: begin
                o_be    = 4'b0001 << i_addr_lo;
                o_wdata = {4{i_wdata[7:0]}};
            end
            SZ_HALF: begin
                o_be       = i_addr_lo[1] ? 4'b1100 : 4'b0011;
                o_wdata    = {2{i_wdata[15:0]}};
                o_misalign = i_addr_lo[0];
            end
            default: begin
                o_misalign = (i_addr_lo != 2'b00);
            end
        endcase
    end

endmodule

// File: rtl/dmem_bridge.sv
// dmem_bridge: bridge from the MIPS M stage to a variable-latency req/ack data bus.
// Loads and (by default) stores run IDLE -> REQ -> DONE; the pipeline is held with stallM
// until the bus acknowledges or the request times out.
// Optional feature macro: DMEM_WBUF_EN adds a one-entry posted-write buffer (StDrain).
// Parameters:
//   BUS_TIMEOUT  cycles to wait for bus_ack before aborting; 0 disables the timeout
// Ports:
//   clk, rst                 clock, asynchronous active-low reset
//   memreadM, memwriteM      load / store request from the M stage
//   sizeM, aluoutM           access size and byte address
//   writedataM               right-aligned store data
//   readdataM                raw aligned bus word of the last completed load
//   stallM, alignerrM        combinational hold / misalignment flag
//   buserrM                  one-cycle pulse after a bus timeout
//   bus_req, bus_we, bus_addr, bus_be, bus_wdata   registered bus request
//   bus_ack, bus_rdata       bus completion and read data
module dmem_bridge
    import dmem_pkg::*;
#(
    parameter int unsigned BUS_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        memreadM,
    input  logic        memwriteM,
    input  logic [1:0]  sizeM,
    input  logic [31:0] aluoutM,
    input  logic [31:0] writedataM,
    output logic [31:0] readdataM,
    output logic        stallM,
    output logic        alignerrM,
    output logic        buserrM,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_wdata,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata
);

    localparam int unsigned CntW = TIMEOUT_W(BUS_TIMEOUT);

    dmem_state_e     r_state;
    logic [CntW-1:0] r_cnt;
    logic [31:0]     r_rdata;
    logic            r_buserr;
    logic            r_req;
    logic            r_we;
    logic [31:0]     r_addr;
    logic [3:0]      r_be;
    logic [31:0]     r_wdata;

    logic            w_access;
    logic            w_misalign;
    logic            w_start;
    logic            w_timeout;
    logic            w_posted;
    logic [3:0]      w_be;
    logic [31:0]     w_wdata;

    dmem_align u_align (
        .i_size     (sizeM),
        .i_addr_lo  (aluoutM[1:0]),
        .i_wdata    (writedataM),
        .o_be       (w_be),
        .o_wdata    (w_wdata),
        .o_misalign (w_misalign)
    );

    assign w_access = memreadM | memwriteM;
    assign w_start  = (r_state == StIdle) && w_access && !w_misalign;

`ifdef DMEM_WBUF_EN
    // A store entering from IDLE retires immediately; the buffer is empty whenever we are in IDLE.
    assign w_posted = memwriteM;
`else
    assign w_posted = 1'b0;
`endif

    // Fires on the cycle whose count would reach BUS_TIMEOUT; a simultaneous ack takes priority.
    assign w_timeout = (BUS_TIMEOUT != 32'd0) && !bus_ack &&
                       ((32'(r_cnt) + 32'd1) == BUS_TIMEOUT);

    always_comb begin
        stallM = 1'b0;
        case (r_state)
            StIdle:  stallM = w_start && !w_posted;
            StReq:   stallM = 1'b1;
            StDone:  stallM = 1'b0;
            StDrain: stallM = w_access;
            default: stallM = 1'b0;
        endcase
    end

    assign alignerrM = (r_state == StIdle) && w_access && w_misalign;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= StIdle;
            r_cnt    <= '0;
            r_rdata  <= '0;
            r_buserr <= 1'b0;
            r_req    <= 1'b0;
            r_we     <= 1'b0;
            r_addr   <= '0;
            r_be     <= '0;
            r_wdata  <= '0;
        end else begin
            r_buserr <= 1'b0;
            case (r_state)
                StIdle: begin
                    if (w_start) begin
                        r_addr  <= {aluoutM[31:2], 2'b00};
                        r_we    <= memwriteM;
                        r_be    <= w_be;
                        r_wdata <= w_wdata;
                        r_req   <= 1'b1;
                        r_cnt   <= '0;
                        r_state <= w_posted ? StDrain : StReq;
                    end
                end
                // A drain uses the same handshake as a request but returns straight to IDLE.
                StReq, StDrain: begin
                    if (bus_ack) begin
                        r_req <= 1'b0;
                        if (r_state == StReq) begin
                            r_rdata <= bus_rdata;
                            r_state <= StDone;
                        end else begin
                            r_state <= StIdle;
                        end
                    end else if (w_timeout) begin
                        r_req    <= 1'b0;
                        r_buserr <= 1'b1;
                        if (r_state == StReq) begin
                            r_rdata <= '0;
                            r_state <= StDone;
                        end else begin
                            r_state <= StIdle;
                        end
                    end else begin
                        r_cnt <= r_cnt + CntW'(1);
                    end
                end
                StDone: begin
                    r_state <= StIdle;
                end
                default: begin
                    r_state <= StIdle;
                end
            endcase
        end
    end

    assign readdataM = r_rdata;
    assign buserrM   = r_buserr;
    assign bus_req   = r_req;
    assign bus_we    = r_we;
    assign bus_addr  = r_addr;
    assign bus_be    = r_be;
    assign bus_wdata = r_wdata;

endmodule

// File: tb/tb_dmem_bridge.sv
// tb_dmem_bridge: self-checking bench for dmem_bridge (BUS_TIMEOUT = 4).
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_dmem_bridge;

`ifdef DMEM_WBUF_EN
    localparam bit WBUF = 1'b1;
`else
    localparam bit WBUF = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        memreadM = 1'b0;
    logic        memwriteM = 1'b0;
    logic [1:0]  sizeM = 2'b00;
    logic [31:0] aluoutM = '0;
    logic [31:0] writedataM = '0;
    logic [31:0] readdataM;
    logic        stallM;
    logic        alignerrM;
    logic        buserrM;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_be;
    logic [31:0] bus_wdata;
    logic        bus_ack = 1'b0;
    logic [31:0] bus_rdata = '0;

    always #5 clk = ~clk;

    dmem_bridge #(
        .BUS_TIMEOUT (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .memreadM   (memreadM),
        .memwriteM  (memwriteM),
        .sizeM      (sizeM),
        .aluoutM    (aluoutM),
        .writedataM (writedataM),
        .readdataM  (readdataM),
        .stallM     (stallM),
        .alignerrM  (alignerrM),
        .buserrM    (buserrM),
        .bus_req    (bus_req),
        .bus_we     (bus_we),
        .bus_addr   (bus_addr),
        .bus_be     (bus_be),
        .bus_wdata  (bus_wdata),
        .bus_ack    (bus_ack),
        .bus_rdata  (bus_rdata)
    );

    typedef struct {
        logic        rd;
        logic        wr;
        logic [1:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          lat;
        logic [31:0] rdata;
        logic        align;
        logic [3:0]  be;
        logic [31:0] baddr;
        logic [31:0] bwdata;
    } vec_t;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic [31:0] rdata;
    } exp_t;

    vec_t vecs[9];
    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        memreadM   = 1'b0;
        memwriteM  = 1'b0;
        sizeM      = 2'b00;
        aluoutM    = '0;
        writedataM = '0;
    endtask

    task automatic drive(input logic rd, input logic wr, input logic [1:0] size,
                         input logic [31:0] addr, input logic [31:0] wdata);
        memreadM   = rd;
        memwriteM  = wr;
        sizeM      = size;
        aluoutM    = addr;
        writedataM = wdata;
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        exp_t e;
        int   stalls;
        bit   posted;
        posted = WBUF && v.wr;
        @(negedge clk);
        drive(v.rd, v.wr, v.size, v.addr, v.wdata);
        #1;
        check($sformatf("v%0d alignerr", idx), 32'(alignerrM), 32'(v.align));
        if (v.align) begin
            check($sformatf("v%0d misaligned stall", idx), 32'(stallM), 32'd0);
            @(negedge clk);
            check($sformatf("v%0d misaligned no req", idx), 32'(bus_req), 32'd0);
            idle_inputs();
            return;
        end
        check($sformatf("v%0d issue stall", idx), 32'(stallM), posted ? 32'd0 : 32'd1);
        stalls = stallM ? 1 : 0;
        e = '{we: v.wr, addr: v.baddr, be: v.be, wdata: v.bwdata, rdata: v.rdata};
        sb.push_back(e);
        for (int c = 0; c <= v.lat; c++) begin
            @(negedge clk);
            if (posted && c == 0) idle_inputs();
            check($sformatf("v%0d req c%0d", idx, c), 32'(bus_req), 32'd1);
            if (c == 0) begin
                e = sb.pop_front();
                check($sformatf("v%0d bus_we", idx), 32'(bus_we), 32'(e.we));
                check($sformatf("v%0d bus_addr", idx), bus_addr, e.addr);
                check($sformatf("v%0d bus_be", idx), 32'(bus_be), 32'(e.be));
                if (e.we) check($sformatf("v%0d bus_wdata", idx), bus_wdata, e.wdata);
            end
            if (stallM) stalls++;
            if (c == v.lat) begin
                bus_ack   = 1'b1;
                bus_rdata = v.rdata;
            end
        end
        @(negedge clk);
        bus_ack   = 1'b0;
        bus_rdata = 32'hDEAD_0000;
        check($sformatf("v%0d req dropped", idx), 32'(bus_req), 32'd0);
        check($sformatf("v%0d done stall", idx), 32'(stallM), 32'd0);
        check($sformatf("v%0d stall cycles", idx), 32'(stalls), posted ? 32'd0 : 32'(v.lat + 2));
        if (v.rd) check($sformatf("v%0d readdata", idx), readdataM, e.rdata);
        idle_inputs();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        int  nreq;
        bit  got_err;

        //       rd    wr    size   addr          wdata         lat rdata
        //       align be       baddr         bwdata
        vecs[0] = '{1'b1, 1'b0, 2'b10, 32'h0000_0100, 32'h0, 2, 32'hCAFE_F00D,
                    1'b0, 4'b1111, 32'h0000_0100, 32'h0};
        vecs[1] = '{1'b0, 1'b1, 2'b00, 32'h0000_0203, 32'h1234_56AB, 1, 32'h1111_2222,
                    1'b0, 4'b1000, 32'h0000_0200, 32'hABAB_ABAB};
        vecs[2] = '{1'b1, 1'b0, 2'b01, 32'h0000_0101, 32'h0, 0, 32'h0,
                    1'b1, 4'b0000, 32'h0, 32'h0};
        vecs[3] = '{1'b0, 1'b1, 2'b01, 32'h0000_0202, 32'hDEAD_BEEF, 0, 32'h3333_4444,
                    1'b0, 4'b1100, 32'h0000_0200, 32'hBEEF_BEEF};
        vecs[4] = '{1'b1, 1'b0, 2'b00, 32'h0000_1001, 32'h0, 0, 32'h0102_0304,
                    1'b0, 4'b0010, 32'h0000_1000, 32'h0};
        vecs[5] = '{1'b1, 1'b0, 2'b11, 32'h0000_0010, 32'h0, 3, 32'h5A5A_A5A5,
                    1'b0, 4'b1111, 32'h0000_0010, 32'h0};
        vecs[6] = '{1'b0, 1'b1, 2'b10, 32'h0000_0206, 32'h7777_7777, 0, 32'h0,
                    1'b1, 4'b0000, 32'h0, 32'h0};
        vecs[7] = '{1'b1, 1'b0, 2'b01, 32'h0000_0000, 32'h0, 1, 32'h0000_FFFF,
                    1'b0, 4'b0011, 32'h0000_0000, 32'h0};
        vecs[8] = '{1'b0, 1'b1, 2'b00, 32'h0000_0000, 32'h0000_007F, 2, 32'h9999_8888,
                    1'b0, 4'b0001, 32'h0000_0000, 32'h7F7F_7F7F};

        // Reset state
        #12;
        check("reset bus_req", 32'(bus_req), 32'd0);
        check("reset bus_we", 32'(bus_we), 32'd0);
        check("reset bus_addr", bus_addr, 32'd0);
        check("reset bus_be", 32'(bus_be), 32'd0);
        check("reset bus_wdata", bus_wdata, 32'd0);
        check("reset readdataM", readdataM, 32'd0);
        check("reset stallM", 32'(stallM), 32'd0);
        check("reset alignerrM", 32'(alignerrM), 32'd0);
        check("reset buserrM", 32'(buserrM), 32'd0);
        @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < 9; i++) begin
            run_vec(i, vecs[i]);
        end

        // Timeout: no ack, BUS_TIMEOUT = 4
        @(negedge clk);
        drive(1'b1, 1'b0, 2'b10, 32'h0000_0400, 32'h0);
        #1;
        check("timeout issue stall", 32'(stallM), 32'd1);
        nreq    = 0;
        got_err = 1'b0;
        for (int c = 0; c < 20 && !got_err; c++) begin
            @(negedge clk);
            if (bus_req) nreq++;
            if (buserrM) got_err = 1'b1;
        end
        check("timeout buserr seen", 32'(got_err), 32'd1);
        check("timeout req cycles", 32'(nreq), 32'd4);
        check("timeout readdata", readdataM, 32'd0);
        check("timeout stall", 32'(stallM), 32'd0);
        check("timeout req low", 32'(bus_req), 32'd0);
        idle_inputs();
        @(negedge clk);
        check("timeout buserr pulse", 32'(buserrM), 32'd0);

        // Reset during REQ
        drive(1'b1, 1'b0, 2'b10, 32'h0000_0104, 32'h0);
        @(negedge clk);
        check("pre-reset req", 32'(bus_req), 32'd1);
        #2 rst = 1'b0;
        #1;
        check("reset mid req", 32'(bus_req), 32'd0);
        check("reset mid addr", bus_addr, 32'd0);
        idle_inputs();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("post-reset req", 32'(bus_req), 32'd0);
        check("post-reset stall", 32'(stallM), 32'd0);
        run_vec(100, vecs[0]);

`ifdef DMEM_WBUF_EN
        // Posted store followed immediately by a load; drain acked after 3 cycles
        @(negedge clk);
        drive(1'b0, 1'b1, 2'b10, 32'h0000_0300, 32'h1122_3344);
        #1;
        check("wbuf store stall", 32'(stallM), 32'd0);
        @(negedge clk);
        drive(1'b1, 1'b0, 2'b10, 32'h0000_0100, 32'h0);
        #1;
        check("wbuf drain we", 32'(bus_we), 32'd1);
        check("wbuf drain addr", bus_addr, 32'h0000_0300);
        check("wbuf drain wdata", bus_wdata, 32'h1122_3344);
        for (int c = 0; c <= 3; c++) begin
            if (c > 0) @(negedge clk);
            check($sformatf("wbuf drain req c%0d", c), 32'(bus_req), 32'd1);
            check($sformatf("wbuf load stall c%0d", c), 32'(stallM), 32'd1);
            if (c == 3) bus_ack = 1'b1;
        end
        @(negedge clk);
        bus_ack = 1'b0;
        check("wbuf drained req", 32'(bus_req), 32'd0);
        check("wbuf load issue stall", 32'(stallM), 32'd1);
        @(negedge clk);
        check("wbuf load req", 32'(bus_req), 32'd1);
        check("wbuf load we", 32'(bus_we), 32'd0);
        check("wbuf load addr", bus_addr, 32'h0000_0100);
        bus_ack   = 1'b1;
        bus_rdata = 32'h600D_F00D;
        @(negedge clk);
        bus_ack = 1'b0;
        check("wbuf load done stall", 32'(stallM), 32'd0);
        check("wbuf load readdata", readdataM, 32'h600D_F00D);
        idle_inputs();
`endif

        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/dmem_bridge.md
# dmem_bridge

Data-memory bridge between the MIPS core's memory (M) stage and a variable-latency request/acknowledge data bus. Accepts the core's single-cycle load/store intent, generates byte enables and lane-replicated write data, runs the bus handshake, returns load data as `readdataM`, and holds the pipeline with `stallM` until the access completes. An optional one-entry posted-write buffer lets stores retire without waiting for the bus.

## Interface
- `BUS_TIMEOUT`, 255: maximum cycles `bus_req` may wait for `bus_ack` before abort; 0 disables the timeout.
- `clk`  in  1  core clock; all state changes on the rising edge.
- `rst`  in  1  asynchronous, active-low reset (low = reset).
- `memreadM`  in  1  load in M stage.
- `memwriteM`  in  1  store in M stage; never high together with `memreadM`.
- `sizeM`  in  2  access size: 00 byte, 01 half, 10 word; 11 treated as word.
- `aluoutM`  in  32  byte address.
- `writedataM`  in  32  store data, right-aligned.
- `readdataM`  out  32  raw aligned bus word for the completed load; the core extracts and extends.
- `stallM`  out  1  hold F..M stages.
- `alignerrM`  out  1  misaligned access flag, same cycle.
- `buserrM`  out  1  one-cycle pulse on bus timeout.
- `bus_req`, `bus_we`  out  1 each  request valid, write.
- `bus_addr`  out  32  word address, bits [1:0] = 0.
- `bus_be`  out  4  byte enables.
- `bus_wdata`  out  32  write data.
- `bus_ack`  in  1  slave completes the current request.
- `bus_rdata`  in  32  read data, valid with `bus_ack`.

## Operation
- FSM states: IDLE, REQ, DONE (plus DRAIN with write buffer).
- IDLE with a valid aligned access: latch addr/we/be/wdata, go to REQ; `stallM`=1 combinationally in that cycle.
- REQ: `bus_req`=1; all bus outputs held stable until `bus_ack` is sampled high. On ack: capture `bus_rdata`, go to DONE.
- DONE: `stallM`=0, `readdataM` = captured word; return to IDLE unconditionally. The core always advances when `stallM`=0, so the same access is never reissued.
- Byte enables: byte `4'b0001 << addr[1:0]`; half `addr[1] ? 1100 : 0011`; word `1111`. Write data: byte `{4{wd[7:0]}}`, half `{2{wd[15:0]}}`, word `wd`. Little-endian.
- Misaligned (half with addr[0]=1, word with addr[1:0]≠0) in IDLE: `alignerrM`=1, no bus request, `stallM`=0.
- Timeout: the counter clears on entering REQ and increments each REQ cycle without ack. When it reaches `BUS_TIMEOUT`: drop `bus_req`, enter DONE with `readdataM`=0 and `buserrM`=1 for that cycle. Ack and timeout in the same cycle: ack wins.

## Timing
- Reset values: `bus_req`=0, `bus_we`=0, `bus_addr`=0, `bus_be`=0, `bus_wdata`=0, `readdataM`=0, `stallM`=0, `alignerrM`=0, `buserrM`=0. FSM=IDLE, buffer empty, counter=0.
- Load issued in M at cycle t with ack latency k≥0 after request: `bus_req` is high from t+1; ack arrives at t+1+k; DONE at t+2+k. Minimum of 3 cycles in M.
- Bus outputs are registered; `stallM` and `alignerrM` are combinational from inputs and state.
- Reset mid-transaction: `bus_req` drops immediately and any in-flight or buffered write is discarded. The slave must tolerate an abandoned request.

## Configuration
- `DMEM_WBUF_EN` defined: a store in IDLE with an empty buffer is captured at cycle t with `stallM`=0 and drained in DRAIN (same handshake as REQ). Any access arriving while the buffer is occupied stalls until the drain is acked, then proceeds normally. A timeout during drain pulses `buserrM` and empties the buffer.
- Not defined: stores follow the load path (IDLE→REQ→DONE) and stall until ack.

## Structure
- `dmem_pkg`: size encodings (`SZ_BYTE`, `SZ_HALF`, `SZ_WORD`), FSM state enum, and the `TIMEOUT_W` width-computation helper.
- Sub-module `dmem_align`: combinational size/address to byte-enable, lane replication, and misalignment detection.

## Test plan
- Word load addr 0x100, ack after 2 cycles with rdata 0xCAFEF00D -> `stallM` high for 4 cycles, then `readdataM`=0xCAFEF00D with `stallM`=0.
- Byte store 0xAB at 0x203 -> `bus_be`=1000, `bus_wdata`=0xABABABAB, `bus_addr`=0x200.
- Half load at 0x101 -> `alignerrM`=1, no `bus_req`, `stallM`=0.
- No ack with `BUS_TIMEOUT`=4 -> `bus_req` high for 4 cycles, then `buserrM` pulse with `readdataM`=0.
- With `DMEM_WBUF_EN`: store then immediate load, store ack after 3 cycles -> no stall on the store; the load stalls until the drain ack, then completes normally.
- `rst` low during REQ -> `bus_req`=0 immediately, FSM in IDLE after release.
